// File: rtl/iob_clint_prog.sv
// IOb initiator driving the CLINT responder: coherent mtime read, tear-free mtimecmp update, msip set/clear.
// Build option: define IOB_CLINT_PROG_SAT_EN to saturate the ARM_REL target instead of wrapping.
module iob_clint_prog #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int N_CORES   = 1,
  parameter int RETRY_MAX = 4
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic                         cke_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [1:0]                   cmd_op_i,
  input  logic [$clog2(N_CORES+1)-1:0] cmd_hart_i,
  input  logic [63:0]                  cmd_value_i,
  output logic                         done_o,
  output logic                         err_o,
  output logic [63:0]                  mtime_o,
  output logic                         iob_avalid_o,
  output logic [ADDR_W-1:0]            iob_addr_o,
  output logic [DATA_W-1:0]            iob_wdata_o,
  output logic [DATA_W/8-1:0]          iob_wstrb_o,
  input  logic                         iob_rvalid_i,
  input  logic [DATA_W-1:0]            iob_rdata_i,
  input  logic                         iob_ready_i
);

  localparam int HART_W  = $clog2(N_CORES + 1);
  localparam int RETRY_W = $clog2(RETRY_MAX + 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX);

  localparam logic [1:0] OP_ARM_REL  = 2'd0;
  localparam logic [1:0] OP_ARM_ABS  = 2'd1;
  localparam logic [1:0] OP_SET_MSIP = 2'd2;

  localparam logic [ADDR_W-1:0] A_MSIP     = ADDR_W'(16'h0000);
  localparam logic [ADDR_W-1:0] A_CMP_LO   = ADDR_W'(16'h4000);
  localparam logic [ADDR_W-1:0] A_CMP_HI   = ADDR_W'(16'h4004);
  localparam logic [ADDR_W-1:0] A_MTIME_LO = ADDR_W'(16'hBFF8);
  localparam logic [ADDR_W-1:0] A_MTIME_HI = ADDR_W'(16'hBFFC);

  typedef enum logic [3:0] {
    IDLE, RD_HI1, RD_LO, RD_HI2, ADD, WR_LO_MAX, WR_HI, WR_LO, WR_MSIP, DONE
  } state_t;

  // Each bus state issues one request, waits for ready, then (reads only) for rvalid.
  typedef enum logic [1:0] {PH_ISSUE, PH_REQ, PH_RESP} phase_t;

  state_t               r_state, w_state;
  phase_t               r_phase, w_phase;
  logic [1:0]           r_op, w_op;
  logic [HART_W-1:0]    r_hart, w_hart;
  logic [63:0]          r_value, w_value, r_target, w_target, r_mtime, w_mtime;
  logic [63:0]          r_mtimeOut, w_mtimeOut, w_addTarget;
  logic [DATA_W-1:0]    r_h1, w_h1, r_lo, w_lo;
  logic [RETRY_W-1:0]   r_retry, w_retry;
  logic                 r_err, w_err;
  logic                 r_avalid, w_avalid;
  logic [ADDR_W-1:0]    r_addr, w_addr, w_reqAddr, w_hartOff;
  logic [DATA_W-1:0]    r_wdata, w_wdata, w_reqData;
  logic [DATA_W/8-1:0]  r_wstrb, w_wstrb;
  logic                 w_busState, w_isRead, w_xferDone;

  assign w_hartOff = ADDR_W'(r_hart);

`ifdef IOB_CLINT_PROG_SAT_EN
  logic [64:0] w_sum;
  assign w_sum       = {1'b0, r_mtime} + {1'b0, r_value};
  assign w_addTarget = w_sum[64] ? {64{1'b1}} : w_sum[63:0];
`else
  assign w_addTarget = r_mtime + r_value;
`endif

  always_comb begin
    w_state = r_state;   w_phase = r_phase;   w_op = r_op;       w_hart = r_hart;
    w_value = r_value;   w_target = r_target; w_mtime = r_mtime; w_mtimeOut = r_mtimeOut;
    w_h1 = r_h1;         w_lo = r_lo;         w_retry = r_retry; w_err = r_err;
    w_avalid = r_avalid; w_addr = r_addr;     w_wdata = r_wdata; w_wstrb = r_wstrb;
    w_busState = 1'b0;   w_isRead = 1'b0;     w_xferDone = 1'b0;
    w_reqAddr = '0;      w_reqData = '0;

    case (r_state)
      RD_HI1, RD_HI2: begin w_busState = 1'b1; w_isRead = 1'b1; w_reqAddr = A_MTIME_HI; end
      RD_LO:     begin w_busState = 1'b1; w_isRead = 1'b1; w_reqAddr = A_MTIME_LO; end
      WR_LO_MAX: begin w_busState = 1'b1; w_reqAddr = A_CMP_LO + (w_hartOff << 3); w_reqData = '1; end
      WR_HI:     begin w_busState = 1'b1; w_reqAddr = A_CMP_HI + (w_hartOff << 3); w_reqData = r_target[63:32]; end
      WR_LO:     begin w_busState = 1'b1; w_reqAddr = A_CMP_LO + (w_hartOff << 3); w_reqData = r_target[31:0]; end
      WR_MSIP:   begin w_busState = 1'b1; w_reqAddr = A_MSIP + (w_hartOff << 2);
                       w_reqData = DATA_W'(r_op == OP_SET_MSIP); end
      default: ;
    endcase

    if (w_busState) begin
      case (r_phase)
        PH_ISSUE: begin
          w_avalid = 1'b1;
          w_addr   = w_reqAddr;
          w_wdata  = w_isRead ? '0 : w_reqData;
          w_wstrb  = w_isRead ? '0 : '1;
          w_phase  = PH_REQ;
        end
        PH_REQ: if (iob_ready_i) begin
          w_avalid = 1'b0;
          if (!w_isRead || iob_rvalid_i) w_xferDone = 1'b1;
          else                           w_phase = PH_RESP;
        end
        PH_RESP: if (iob_rvalid_i) w_xferDone = 1'b1;
        default: w_phase = PH_ISSUE;
      endcase
      if (w_xferDone) w_phase = PH_ISSUE;
    end

    case (r_state)
      IDLE: if (cmd_valid_i) begin
        w_op = cmd_op_i; w_hart = cmd_hart_i; w_value = cmd_value_i; w_target = cmd_value_i;
        w_retry = '0;    w_err = 1'b0;        w_phase = PH_ISSUE;
        if (32'(cmd_hart_i) >= 32'(N_CORES)) begin
          w_err = 1'b1; w_state = DONE;
        end else begin
          case (cmd_op_i)
            OP_ARM_REL: w_state = RD_HI1;
            OP_ARM_ABS: w_state = WR_LO_MAX;
            default:    w_state = WR_MSIP;
          endcase
        end
      end
      RD_HI1: if (w_xferDone) begin w_h1 = iob_rdata_i; w_state = RD_LO; end
      RD_LO:  if (w_xferDone) begin w_lo = iob_rdata_i; w_state = RD_HI2; end
      // A changed high word means the low word may have wrapped between reads.
      RD_HI2: if (w_xferDone) begin
        if (iob_rdata_i == r_h1) begin
          w_mtime = {r_h1, r_lo}; w_state = ADD;
        end else begin
          w_h1 = iob_rdata_i; w_retry = r_retry + RETRY_W'(1);
          if (w_retry == RETRY_LAST) begin w_err = 1'b1; w_state = DONE; end
          else                             w_state = RD_LO;
        end
      end
      ADD:       begin w_target = w_addTarget; w_state = WR_LO_MAX; end
      WR_LO_MAX: if (w_xferDone) w_state = WR_HI;
      WR_HI:     if (w_xferDone) w_state = WR_LO;
      WR_LO: if (w_xferDone) begin
        if (r_op == OP_ARM_REL) w_mtimeOut = r_mtime;
        w_state = DONE;
      end
      WR_MSIP:   if (w_xferDone) w_state = DONE;
      DONE:      w_state = IDLE;
      default:   w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      r_state <= IDLE;  r_phase <= PH_ISSUE; r_op <= '0;     r_hart <= '0;
      r_value <= '0;    r_target <= '0;      r_mtime <= '0;  r_mtimeOut <= '0;
      r_h1 <= '0;       r_lo <= '0;          r_retry <= '0;  r_err <= 1'b0;
      r_avalid <= 1'b0; r_addr <= '0;        r_wdata <= '0;  r_wstrb <= '0;
    end else if (cke_i) begin
      r_state <= w_state;   r_phase <= w_phase;   r_op <= w_op;       r_hart <= w_hart;
      r_value <= w_value;   r_target <= w_target; r_mtime <= w_mtime; r_mtimeOut <= w_mtimeOut;
      r_h1 <= w_h1;         r_lo <= w_lo;         r_retry <= w_retry; r_err <= w_err;
      r_avalid <= w_avalid; r_addr <= w_addr;     r_wdata <= w_wdata; r_wstrb <= w_wstrb;
    end
  end

  assign cmd_ready_o  = (r_state == IDLE);
  assign done_o       = (r_state == DONE);
  assign err_o        = done_o & r_err;
  assign mtime_o      = r_mtimeOut;
  assign iob_avalid_o = r_avalid;
  assign iob_addr_o   = r_addr;
  assign iob_wdata_o  = r_wdata;
  assign iob_wstrb_o  = r_wstrb;

endmodule

// File: tb/tb_iob_clint_prog.sv
// Directed self-checking bench for iob_clint_prog with a scripted IOb responder model.
module tb_iob_clint_prog;

  logic        clk = 1'b0;
  logic        arst, cke, cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [0:0]  cmd_hart;
  logic [63:0] cmd_value, mtime;
  logic        done, err;
  logic        avalid, rvalid, ready;
  logic [15:0] addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  logic [31:0] rdQ[$];
  logic [15:0] logAddr[$];
  logic [31:0] logData[$];
  logic        logWr[$];
  int          stallCfg = 0;
  bit          sameCycle = 0;
  bit          blockEn = 0;
  logic [15:0] blockAddr = 16'h0;
  int          doneCount = 0;
  int          avalidCycles = 0;

  always #5 clk = ~clk;

  iob_clint_prog dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_hart_i(cmd_hart), .cmd_value_i(cmd_value),
    .done_o(done), .err_o(err), .mtime_o(mtime),
    .iob_avalid_o(avalid), .iob_addr_o(addr), .iob_wdata_o(wdata), .iob_wstrb_o(wstrb),
    .iob_rvalid_i(rvalid), .iob_rdata_i(rdata), .iob_ready_i(ready)
  );

  // Responder: stalls stallCfg cycles per request, logs accepted requests, returns scripted read data.
  initial begin
    bit rdPending = 0;
    bit counting  = 0;
    int waitN     = 0;
    ready = 1'b0; rvalid = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      ready = 1'b0; rvalid = 1'b0;
      if (rdPending) begin
        rvalid = 1'b1;
        rdata  = (rdQ.size() > 0) ? rdQ.pop_front() : 32'hDEADBEEF;
        rdPending = 0;
      end else if (!avalid) begin
        counting = 0;
      end else if (!(blockEn && addr == blockAddr)) begin
        if (!counting) begin counting = 1; waitN = stallCfg; end
        if (waitN > 0) waitN--;
        else begin
          ready = 1'b1; counting = 0;
          logAddr.push_back(addr); logData.push_back(wdata); logWr.push_back(wstrb == 4'hF);
          if (wstrb == 4'h0) begin
            if (sameCycle) begin
              rvalid = 1'b1;
              rdata  = (rdQ.size() > 0) ? rdQ.pop_front() : 32'hDEADBEEF;
            end else rdPending = 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done)   doneCount++;
      if (avalid) avalidCycles++;
    end
  end

  task automatic clearLog();
    logAddr.delete(); logData.delete(); logWr.delete(); rdQ.delete();
  endtask

  task automatic issueCmd(input logic [1:0] op, input logic [0:0] hart, input logic [63:0] val,
                          output logic sawDone, output logic sawErr, output logic [63:0] sawMtime);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_hart = hart; cmd_value = val;
    @(negedge clk);
    cmd_valid = 1'b0;
    sawDone = 1'b0; sawErr = 1'b0; sawMtime = '0;
    for (int i = 0; i < 500 && !sawDone; i++) begin
      if (done) begin sawDone = 1'b1; sawErr = err; sawMtime = mtime; end
      else @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    arst = 1'b1; cke = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_hart = '0; cmd_value = '0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
    checks++; if (done !== 1'b0)      begin errors++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
    checks++; if (err !== 1'b0)       begin errors++; $display("[TB] FAIL reset_err: got %0b want 0", err); end
    checks++; if (mtime !== 64'h0)    begin errors++; $display("[TB] FAIL reset_mtime: got %h want 0", mtime); end
    checks++; if (avalid !== 1'b0)    begin errors++; $display("[TB] FAIL reset_avalid: got %0b want 0", avalid); end
    checks++; if ({addr, wdata, wstrb} !== 52'h0) begin errors++;
      $display("[TB] FAIL reset_bus: got addr %h wdata %h wstrb %h want all 0", addr, wdata, wstrb); end
    arst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arm_rel();
    logic d, e; logic [63:0] m;
    logic [15:0] expA[6] = '{16'hBFFC, 16'hBFF8, 16'hBFFC, 16'h4000, 16'h4004, 16'h4000};
    logic [31:0] expD[6] = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h564};
    logic        expW[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    clearLog(); sameCycle = 0;
    rdQ = '{32'h0, 32'h500, 32'h0};
    issueCmd(2'd0, 1'b0, 64'd100, d, e, m);
    checks++; if (d !== 1'b1) begin errors++; $display("[TB] FAIL arm_rel_done: got %0b want 1", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL arm_rel_err: got %0b want 0", e); end
    checks++; if (m !== 64'h500) begin errors++; $display("[TB] FAIL arm_rel_mtime: got %h want 500", m); end
    checks++; if (logAddr.size() !== 6) begin errors++; $display("[TB] FAIL arm_rel_count: got %0d want 6", logAddr.size()); end
    for (int i = 0; i < 6 && i < logAddr.size(); i++) begin
      checks++;
      if (logAddr[i] !== expA[i] || logWr[i] !== expW[i] || (expW[i] && logData[i] !== expD[i])) begin
        errors++;
        $display("[TB] FAIL arm_rel_txn%0d: got addr %h wr %0b data %h want addr %h wr %0b data %h",
                 i, logAddr[i], logWr[i], logData[i], expA[i], expW[i], expD[i]);
      end
    end
  endtask

  task automatic test_rollover();
    logic d, e; logic [63:0] m;
    logic [15:0] expA[8] = '{16'hBFFC, 16'hBFF8, 16'hBFFC, 16'hBFF8, 16'hBFFC, 16'h4000, 16'h4004, 16'h4000};
    logic [31:0] expD[8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h120};
    logic        expW[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    clearLog(); sameCycle = 1;
    rdQ = '{32'h0, 32'h10, 32'h1, 32'h20, 32'h1};
    issueCmd(2'd0, 1'b0, 64'h100, d, e, m);
    sameCycle = 0;
    checks++; if (d !== 1'b1 || e !== 1'b0) begin errors++; $display("[TB] FAIL rollover_status: got done %0b err %0b want 1 0", d, e); end
    checks++; if (m !== 64'h1_00000020) begin errors++; $display("[TB] FAIL rollover_mtime: got %h want 100000020", m); end
    checks++; if (logAddr.size() !== 8) begin errors++; $display("[TB] FAIL rollover_count: got %0d want 8", logAddr.size()); end
    for (int i = 0; i < 8 && i < logAddr.size(); i++) begin
      checks++;
      if (logAddr[i] !== expA[i] || logWr[i] !== expW[i] || (expW[i] && logData[i] !== expD[i])) begin
        errors++;
        $display("[TB] FAIL rollover_txn%0d: got addr %h wr %0b data %h want addr %h wr %0b data %h",
                 i, logAddr[i], logWr[i], logData[i], expA[i], expW[i], expD[i]);
      end
    end
  endtask

  task automatic test_retry_overflow();
    logic d, e; logic [63:0] m; int writes = 0;
    clearLog();
    rdQ = '{32'h1, 32'h0, 32'h2, 32'h0, 32'h3, 32'h0, 32'h4, 32'h0, 32'h5};
    issueCmd(2'd0, 1'b0, 64'd7, d, e, m);
    foreach (logWr[i]) if (logWr[i]) writes++;
    checks++; if (d !== 1'b1 || e !== 1'b1) begin errors++; $display("[TB] FAIL retry_status: got done %0b err %0b want 1 1", d, e); end
    checks++; if (logAddr.size() !== 9) begin errors++; $display("[TB] FAIL retry_reads: got %0d want 9", logAddr.size()); end
    checks++; if (writes !== 0) begin errors++; $display("[TB] FAIL retry_no_write: got %0d writes want 0", writes); end
    checks++; if (m !== 64'h1_00000020) begin errors++; $display("[TB] FAIL retry_mtime_kept: got %h want 100000020", m); end
  endtask

  task automatic test_wrap();
    logic d, e; logic [63:0] m;
`ifdef IOB_CLINT_PROG_SAT_EN
    logic [31:0] expHi = 32'hFFFFFFFF, expLo = 32'hFFFFFFFF;
`else
    logic [31:0] expHi = 32'h0, expLo = 32'h1;
`endif
    clearLog();
    rdQ = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    issueCmd(2'd0, 1'b0, 64'd2, d, e, m);
    checks++; if (d !== 1'b1 || e !== 1'b0) begin errors++; $display("[TB] FAIL wrap_status: got done %0b err %0b want 1 0", d, e); end
    checks++; if (m !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("[TB] FAIL wrap_mtime: got %h want all ones", m); end
    checks++; if (logAddr.size() !== 6) begin errors++; $display("[TB] FAIL wrap_count: got %0d want 6", logAddr.size()); end
    else begin
      checks++; if (logAddr[4] !== 16'h4004 || logData[4] !== expHi) begin errors++;
        $display("[TB] FAIL wrap_hi: got addr %h data %h want 4004 %h", logAddr[4], logData[4], expHi); end
      checks++; if (logAddr[5] !== 16'h4000 || logData[5] !== expLo) begin errors++;
        $display("[TB] FAIL wrap_lo: got addr %h data %h want 4000 %h", logAddr[5], logData[5], expLo); end
    end
  endtask

  task automatic test_msip_stall();
    bit found = 0; int bad = 0; int doneBase; bit seenDone = 0;
    clearLog(); stallCfg = 5; doneBase = doneCount;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_hart = 1'b0; cmd_value = '0;
    @(negedge clk);
    cmd_op = 2'd3;
    for (int i = 0; i < 50 && !found; i++) begin
      if (avalid) found = 1; else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL msip_avalid: got no request want one"); end
    for (int i = 0; i < 5; i++) begin
      if (!(avalid === 1'b1 && addr === 16'h0 && wdata === 32'h1 && wstrb === 4'hF && ready === 1'b0)) bad++;
      if (i < 4) @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL msip_stable: got %0d unstable cycles want 0", bad); end
    for (int i = 0; i < 50 && !seenDone; i++) begin
      if (done) seenDone = 1; else @(negedge clk);
    end
    repeat (4) @(negedge clk);
    stallCfg = 0;
    checks++; if (doneCount - doneBase !== 1) begin errors++; $display("[TB] FAIL msip_done_pulses: got %0d want 1", doneCount - doneBase); end
    checks++; if (logAddr.size() !== 1) begin errors++; $display("[TB] FAIL msip_writes: got %0d want 1", logAddr.size()); end
    else begin
      checks++; if (logAddr[0] !== 16'h0 || logData[0] !== 32'h1 || logWr[0] !== 1'b1) begin errors++;
        $display("[TB] FAIL msip_txn: got addr %h data %h wr %0b want 0000 1 1", logAddr[0], logData[0], logWr[0]); end
    end
  endtask

  task automatic test_bad_hart();
    logic d, e; logic [63:0] m; int avBase;
    clearLog(); avBase = avalidCycles;
    issueCmd(2'd3, 1'b1, 64'h0, d, e, m);
    checks++; if (d !== 1'b1 || e !== 1'b1) begin errors++; $display("[TB] FAIL bad_hart_status: got done %0b err %0b want 1 1", d, e); end
    checks++; if (avalidCycles !== avBase) begin errors++; $display("[TB] FAIL bad_hart_bus: got %0d avalid cycles want 0", avalidCycles - avBase); end
  endtask

  task automatic test_reset_midflight();
    logic d, e; logic [63:0] m; bit found = 0;
    clearLog(); blockEn = 1; blockAddr = 16'h4004;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_hart = 1'b0; cmd_value = 64'h12345678_9ABCDEF0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (avalid && addr == 16'h4004) found = 1; else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL midflight_wr_hi: got no WR_HI request want one"); end
    arst = 1'b1;
    @(negedge clk);
    checks++; if (avalid !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
      $display("[TB] FAIL midflight_abort: got avalid %0b ready %0b want 0 1", avalid, cmd_ready); end
    checks++; if (mtime !== 64'h0) begin errors++; $display("[TB] FAIL midflight_mtime_clr: got %h want 0", mtime); end
    arst = 1'b0; blockEn = 0;
    clearLog();
    issueCmd(2'd1, 1'b0, 64'h00000002_00000010, d, e, m);
    checks++; if (d !== 1'b1 || e !== 1'b0) begin errors++; $display("[TB] FAIL abs_status: got done %0b err %0b want 1 0", d, e); end
    checks++; if (m !== 64'h0) begin errors++; $display("[TB] FAIL abs_mtime_unchanged: got %h want 0", m); end
    checks++;
    if (logAddr.size() !== 3 || logAddr[0] !== 16'h4000 || logData[0] !== 32'hFFFFFFFF ||
        logAddr[1] !== 16'h4004 || logData[1] !== 32'h2 || logAddr[2] !== 16'h4000 || logData[2] !== 32'h10) begin
      errors++;
      $display("[TB] FAIL abs_writes: got %0d txns want 4000=FFFFFFFF 4004=2 4000=10", logAddr.size());
    end
  endtask

  initial begin
    test_reset();
    test_arm_rel();
    test_rollover();
    test_retry_overflow();
    test_wrap();
    test_msip_stall();
    test_bad_hart();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
